i2c_clk_gen: RTL and testbench
==============================

I2C_CLK_GEN -- requirements
Module: i2c_clk_gen

Interface
REQ-001 Parameter DIVIDER, default 500: clk cycles per SCL quarter-period; legal range 4 and above.
REQ-002 Parameter TIMEOUT, default 4096: maximum stretch length in clk cycles; used only when the stretch-timeout feature is compiled in.
REQ-003 Localparam CBITS = $clog2(4*DIVIDER): phase counter width.
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ena  input  1  run request; level-sensitive.
REQ-007 scl_in  input  1  raw SCL bus level; asynchronous to clk.
REQ-008 scl_oe  output  1  1 = drive SCL low; 0 = release SCL.
REQ-009 data_clk  output  1  SDA update/sample strobe clock, in quadrature with SCL.
REQ-010 phase  output  2  current quarter: 0=Q0, 1=Q1, 2=Q2, 3=Q3.
REQ-011 stretching  output  1  1 while a slave is holding SCL low.
REQ-012 timeout  output  1  sticky stretch-timeout flag.

Function
REQ-013 scl_in SHALL pass through a 2-flop synchroniser; the synchronised signal is scl_s.
REQ-014 The FSM states SHALL be IDLE, RUN, STRETCH and TOUT.
REQ-015 In IDLE, cnt SHALL be 0 and ena=1 SHALL move the FSM to RUN; the first RUN cycle has cnt=0.
REQ-016 In RUN, cnt SHALL increment by 1 per cycle and wrap from 4*DIVIDER-1 to 0; no other wrap values are allowed.
REQ-017 If ena=0 in RUN at cnt=4*DIVIDER-1, the FSM SHALL go to IDLE; a low ena mid-period SHALL NOT truncate the period.
REQ-018 In RUN at cnt=2*DIVIDER+2 with scl_s=0, the FSM SHALL go to STRETCH and cnt SHALL hold.
REQ-019 The +2 offset in REQ-018 SHALL equal the synchroniser latency; scl_s=0 at any other cnt SHALL be ignored.
REQ-020 In STRETCH, cnt SHALL hold and scl_s=1 SHALL return the FSM to RUN, with cnt incrementing on that same edge.
REQ-021 phase SHALL equal cnt/DIVIDER in RUN and STRETCH, and 0 in IDLE and TOUT.
REQ-022 scl_oe SHALL be 1 only in RUN with phase 0 or 1.
REQ-023 data_clk SHALL be 1 only in RUN or STRETCH with phase 1 or 2.
REQ-024 stretching SHALL be 1 exactly when the state is STRETCH.
REQ-025 Outputs SHALL be decoded only from registered state and cnt, with no combinational path from any input.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, cnt=0, the stretch counter to 0 and both synchroniser flops to 1.
REQ-027 During reset the outputs SHALL be scl_oe=0, data_clk=0, phase=0, stretching=0 and timeout=0.
REQ-028 rst asserted mid-period or mid-stretch SHALL release SCL (scl_oe=0) immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro I2C_CLK_STRETCH_TIMEOUT_EN SHALL compile the stretch timeout in or out.
REQ-030 When defined: a stretch counter SHALL clear on STRETCH entry and count each STRETCH cycle.
REQ-031 When defined: reaching TIMEOUT SHALL move the FSM to TOUT with timeout=1 and scl_oe=0.
REQ-032 When defined: TOUT SHALL go to IDLE only when ena=0, and timeout SHALL clear on that transition.
REQ-033 When defined, scl_s=1 and the TIMEOUT count in the same cycle SHALL resolve to RUN.
REQ-034 When undefined: stretching SHALL be unbounded, TOUT and the stretch counter SHALL be absent, and timeout SHALL be tied to 0 with the port retained.

Structure
REQ-035 Package i2c_clk_pkg SHALL hold the FSM state enum, the phase enum (Q0..Q3) and the SYNC_STAGES=2 constant.
REQ-036 Sub-module i2c_sync SHALL be the 2-flop synchroniser, parametrised by reset value.
REQ-037 Total RTL SHALL be roughly 150-250 lines.

Verification (DIVIDER=4, TIMEOUT=16)
REQ-038 With rst released, ena=1 and scl_in following ~scl_oe: period = 16 cycles; scl_oe=1 for cnt 0-7; data_clk=1 for cnt 4-11; stretching never 1.
REQ-039 Slave holds scl_in=0 for 10 cycles past release: STRETCH is entered at cnt=10, cnt holds, stretching=1, and RUN resumes 2 cycles after scl_in rises; period = 16 + stretch length.
REQ-040 ena dropped at cnt=5: the period completes to cnt=15, then IDLE with scl_oe=0.
REQ-041 rst pulsed at cnt=3 between clock edges: scl_oe and cnt=0 fall before the next edge; after release, the FSM is in IDLE until ena is seen.
REQ-042 With the macro defined and scl_in held 0: timeout=1 after 16 STRETCH cycles, scl_oe=0; timeout holds until ena=0, then IDLE.
REQ-043 With the macro undefined and the same stimulus: STRETCH persists for 1000 cycles and timeout stays 0.

Source files
------------

// File: rtl/i2c_clk_pkg.sv
// rtl/i2c_clk_pkg.sv - shared types and constants for the I2C SCL clock generator
package i2c_clk_pkg;

    // Depth of the scl_in synchroniser; it is also the look-ahead used by the stretch check
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STRETCH = 2'd2,
        TOUT    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } phase_t;

endpackage

// File: rtl/i2c_sync.sv
// rtl/i2c_sync.sv - two-flop synchroniser with configurable reset value
module i2c_sync
    import i2c_clk_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // Shift the asynchronous input through the flop chain; reset loads the idle level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {SYNC_STAGES{RST_VAL}};
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/i2c_clk_gen.sv
// rtl/i2c_clk_gen.sv - I2C SCL generator with clock stretching; optional timeout via I2C_CLK_STRETCH_TIMEOUT_EN
module i2c_clk_gen
    import i2c_clk_pkg::*;
#(
    parameter int DIVIDER = 500,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       scl_in,
    output logic       scl_oe,
    output logic       data_clk,
    output logic [1:0] phase,
    output logic       stretching,
    output logic       timeout
);

    localparam int CBITS = $clog2(4*DIVIDER);

    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(4*DIVIDER - 1);
    // SCL was released at 2*DIVIDER; the synchroniser shows the bus level SYNC_STAGES cycles later
    localparam logic [CBITS-1:0] CNT_CHK  = CBITS'(2*DIVIDER + SYNC_STAGES);
    localparam logic [CBITS-1:0] Q1_START = CBITS'(DIVIDER);
    localparam logic [CBITS-1:0] Q2_START = CBITS'(2*DIVIDER);
    localparam logic [CBITS-1:0] Q3_START = CBITS'(3*DIVIDER);

    state_t           state, state_nx;
    logic [CBITS-1:0] cnt, cnt_nx, cnt_inc;
    logic             scl_s;
    phase_t           ph, phase_q;

`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
    localparam int SBITS = $clog2(TIMEOUT + 1);
    localparam logic [SBITS-1:0] SCNT_LAST = SBITS'(TIMEOUT - 1);
    // scnt holds the number of STRETCH cycles already completed before the current one
    logic [SBITS-1:0] scnt, scnt_nx;
`endif

    i2c_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (scl_in),
        .q   (scl_s)
    );

    assign cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + CBITS'(1);

    // State, phase counter and stretch counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
            scnt  <= '0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
            scnt  <= scnt_nx;
`endif
        end
    end

    // Next state: periods always run to completion; the bus is only checked once per period
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
        scnt_nx  = scnt;
`endif
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (ena) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_CHK && !scl_s) begin
                    state_nx = STRETCH;
`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
                    scnt_nx  = '0;
`endif
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt == CNT_LAST && !ena) begin
                        state_nx = IDLE;
                    end
                end
            end
            STRETCH: begin
                if (scl_s) begin
                    // A slave release wins over a simultaneous timeout
                    state_nx = RUN;
                    cnt_nx   = cnt_inc;
                end
`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
                else if (scnt == SCNT_LAST) begin
                    state_nx = TOUT;
                    cnt_nx   = '0;
                end else begin
                    scnt_nx = scnt + SBITS'(1);
                end
`endif
            end
`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
            TOUT: begin
                cnt_nx = '0;
                if (!ena) begin
                    state_nx = IDLE;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs decoded purely from registered state and cnt
    always_comb begin
        scl_oe     = 1'b0;
        data_clk   = 1'b0;
        stretching = 1'b0;
        phase_q    = Q0;
        if (cnt < Q1_START) begin
            ph = Q0;
        end else if (cnt < Q2_START) begin
            ph = Q1;
        end else if (cnt < Q3_START) begin
            ph = Q2;
        end else begin
            ph = Q3;
        end
        case (state)
            RUN: begin
                phase_q  = ph;
                scl_oe   = (ph == Q0) || (ph == Q1);
                data_clk = (ph == Q1) || (ph == Q2);
            end
            STRETCH: begin
                phase_q    = ph;
                data_clk   = (ph == Q1) || (ph == Q2);
                stretching = 1'b1;
            end
            default: ;
        endcase
    end

    assign phase = phase_q;

`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
    assign timeout = (state == TOUT);
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_clk_gen.sv
// tb/tb_i2c_clk_gen.sv - directed self-checking bench for i2c_clk_gen (DIVIDER=4, TIMEOUT=16)
module tb_i2c_clk_gen;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       scl_in;
    logic       hold;
    logic       scl_oe;
    logic       data_clk;
    logic [1:0] phase;
    logic       stretching;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Open-drain bus: low when the master drives or the slave holds
    assign scl_in = ~scl_oe & ~hold;

    i2c_clk_gen #(
        .DIVIDER (4),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .scl_in     (scl_in),
        .scl_oe     (scl_oe),
        .data_clk   (data_clk),
        .phase      (phase),
        .stretching (stretching),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int e_oe, input int e_dc, input int e_ph,
                           input int e_st, input int e_to, input int e_cnt);
        chk({tag, " scl_oe"},     32'(scl_oe),     32'(e_oe));
        chk({tag, " data_clk"},   32'(data_clk),   32'(e_dc));
        chk({tag, " phase"},      32'(phase),      32'(e_ph));
        chk({tag, " stretching"}, 32'(stretching), 32'(e_st));
        chk({tag, " timeout"},    32'(timeout),    32'(e_to));
        chk({tag, " cnt"},        32'(dut.cnt),    32'(e_cnt));
    endtask

    // Expected RUN outputs at count c for DIVIDER=4: SCL low for 0-7, data_clk high for 4-11
    task automatic chk_run(input string tag, input int c);
        chk_all($sformatf("%s run c%0d", tag, c), (c < 8) ? 1 : 0,
                (c >= 4 && c < 12) ? 1 : 0, c / 4, 0, 0, c);
    endtask

    task automatic chk_stretch(input string tag);
        chk_all(tag, 0, 1, 2, 1, 0, 10);
    endtask

    task automatic chk_idle(input string tag);
        chk_all(tag, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst  = 1'b1;
        ena  = 1'b0;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("idle after reset");

        // Two free-running periods, including the wrap
        ena = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk_run("free", i % 16);
        end

        // Slave holds SCL low for 10 cycles past release
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk_run("pre-stretch", c);
            if (c == 7) hold = 1'b1;
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk_stretch($sformatf("stretch k%0d", k));
            if (k == 7) hold = 1'b0;
        end
        for (int c = 11; c <= 15; c++) begin
            @(negedge clk);
            chk_run("post-stretch", c);
        end

        // ena dropped at cnt=5 must not truncate the period
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            chk_run("ena-drop", c);
            if (c == 5) ena = 1'b0;
        end
        @(negedge clk);
        chk_idle("idle after ena drop");
        @(negedge clk);
        chk_idle("idle held");

        // Asynchronous reset mid-period at cnt=3
        ena = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            chk_run("pre-rst", c);
        end
        #1;
        rst = 1'b1;
        ena = 1'b0;
        #1;
        chk_idle("async rst");
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle($sformatf("idle after rst %0d", i));
        end

        // Slave holds SCL low indefinitely
        ena = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk_run("pre-hold", c);
            if (c == 7) hold = 1'b1;
        end
`ifdef I2C_CLK_STRETCH_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk_stretch($sformatf("tout stretch k%0d", k));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_all($sformatf("tout %0d", i), 0, 0, 0, 0, 1, 0);
        end
        ena = 1'b0;
        @(negedge clk);
        chk_idle("idle after tout");
        hold = 1'b0;
`else
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            chk_stretch($sformatf("long stretch k%0d", k));
        end
        hold = 1'b0;
        for (int k = 1001; k <= 1002; k++) begin
            @(negedge clk);
            chk_stretch($sformatf("long stretch k%0d", k));
        end
        @(negedge clk);
        chk_run("after long stretch", 11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
